// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared state type and byte-strobe helpers for data_mem_be
package data_mem_pkg;

    typedef enum logic {CLEAR, RUN} mem_state_t;

    localparam int MAX_W = 256;
    localparam int MAX_B = MAX_W / 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] strb_mask(input logic [MAX_B-1:0] strb);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_B; i++) m[8*i +: 8] = {8{strb[i]}};
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_word,
                                                    input logic [MAX_W-1:0] new_word,
                                                    input logic [MAX_B-1:0] strb);
        logic [MAX_W-1:0] m;
        m = strb_mask(strb);
        return (old_word & ~m) | (new_word & m);
    endfunction

endpackage

// File: rtl/data_mem_clear_seq.sv
// data_mem_clear_seq: CLEAR/RUN sequencer sweeping one word per cycle to zero
module data_mem_clear_seq
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    output logic             busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx,
    output logic             sweep_start
);

    mem_state_t       state;
    logic [IDX_W-1:0] ptr;

    // Sweep pointer walks 0..DEPTH-1; clear_req restarts it from either state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else if (clear_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else if (state == CLEAR) begin
            if (ptr == IDX_W'(DEPTH - 1)) begin
                state <= RUN;
                ptr   <= '0;
                busy  <= 1'b0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    assign clr_we      = (state == CLEAR);
    assign clr_idx     = ptr;
    assign sweep_start = clear_req;

endmodule

// File: rtl/data_mem_be.sv
// data_mem_be: byte-strobed word RAM, two registered read ports, zero sweep.
// DATA_MEM_BYPASS_EN selects write-first reads; undefined gives read-first.
module data_mem_be
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SIZE   = 4096,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    input  logic                write_en,
    input  logic [DATA_W/8-1:0] write_strb,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [ADDR_W-1:0]   read_addrA,
    input  logic [ADDR_W-1:0]   read_addrB,
    output logic [DATA_W-1:0]   read_dataA,
    output logic [DATA_W-1:0]   read_dataB,
    output logic                busy,
    output logic                addr_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = SIZE / BYTES;
    localparam int OFF_W = clog2(BYTES);
    localparam int IDX_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ((a & ADDR_W'(BYTES - 1)) == '0) && (a < ADDR_W'(SIZE));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we, sweep_start;
    logic [IDX_W-1:0]  clr_idx;
    logic              wr_ok, ra_ok, rb_ok, wr_hit;
    logic [IDX_W-1:0]  w_idx, a_idx, b_idx;
    logic [DATA_W-1:0] wr_word, rd_a, rd_b;

    data_mem_clear_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .clr_we     (clr_we),
        .clr_idx    (clr_idx),
        .sweep_start(sweep_start)
    );

    assign wr_ok   = addr_ok(write_addr);
    assign ra_ok   = addr_ok(read_addrA);
    assign rb_ok   = addr_ok(read_addrB);
    assign w_idx   = to_idx(write_addr);
    assign a_idx   = to_idx(read_addrA);
    assign b_idx   = to_idx(read_addrB);
    assign wr_hit  = !busy && write_en && wr_ok && (|write_strb);
    assign wr_word = DATA_W'(byte_merge(MAX_W'(mem[w_idx]), MAX_W'(write_data), MAX_B'(write_strb)));

`ifdef DATA_MEM_BYPASS_EN
    assign rd_a = (wr_hit && w_idx == a_idx) ? wr_word : mem[a_idx];
    assign rd_b = (wr_hit && w_idx == b_idx) ? wr_word : mem[b_idx];
`else
    assign rd_a = mem[a_idx];
    assign rd_b = mem[b_idx];
`endif

    // Array port: sweep zeros one word per cycle, otherwise strobed merge write
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_idx] <= '0;
        else if (wr_hit)
            mem[w_idx] <= wr_word;
    end

    // Registered reads; zero while sweeping or for an illegal address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_dataA <= '0;
            read_dataB <= '0;
        end else begin
            read_dataA <= (busy || !ra_ok) ? '0 : rd_a;
            read_dataB <= (busy || !rb_ok) ? '0 : rd_b;
        end
    end

    // Sticky illegal-access flag, cleared when a new sweep is requested
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            addr_err <= 1'b0;
        else if (sweep_start)
            addr_err <= 1'b0;
        else if (!busy && ((write_en && !wr_ok) || !ra_ok || !rb_ok))
            addr_err <= 1'b1;
    end

endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed checks of data_mem_be at DATA_W=32, SIZE=64
module tb_data_mem_be;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_req = 1'b0;
    logic        write_en = 1'b0;
    logic [3:0]  write_strb = '0;
    logic [31:0] write_addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_addrA = '0;
    logic [31:0] read_addrB = '0;
    logic [31:0] read_dataA, read_dataB;
    logic        busy, addr_err;
    int          checks = 0;
    int          errors = 0;
    int          n;

    data_mem_be #(.DATA_W(32), .SIZE(64), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .write_en  (write_en),
        .write_strb(write_strb),
        .write_addr(write_addr),
        .write_data(write_data),
        .read_addrA(read_addrA),
        .read_addrB(read_addrB),
        .read_dataA(read_dataA),
        .read_dataB(read_dataB),
        .busy      (busy),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        write_en   = 1'b1;
        write_addr = addr;
        write_data = data;
        write_strb = strb;
        step();
        write_en   = 1'b0;
        write_strb = '0;
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        check(tag, n, 16);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            read_addrA = 4 * i;
            read_addrB = 4 * (15 - i);
            step();
            check($sformatf("%sA%0d", tag, i), read_dataA, 0);
            check($sformatf("%sB%0d", tag, i), read_dataB, 0);
        end
        read_addrA = '0;
        read_addrB = '0;
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 1);
        check("rst_rdA", read_dataA, 0);
        check("rst_rdB", read_dataB, 0);
        check("rst_err", addr_err, 0);
        reset = 1'b1;
        count_busy("init_sweep_len");
        read_all_zero("init");
        check("idle_busy", busy, 0);

        wr(32'h8, 32'hDEADBEEF, 4'b1111);
        wr(32'h8, 32'h000000AA, 4'b0001);
        read_addrA = 32'h8;
        step();
        check("merge_rd", read_dataA, 32'hDEADBEAA);

        wr(32'h8, 32'h55555555, 4'b0000);
        step();
        check("strb0_noop", read_dataA, 32'hDEADBEAA);

        read_addrA = 32'h4;
        wr(32'h4, 32'h12345678, 4'b1111);
`ifdef DATA_MEM_BYPASS_EN
        check("same_cyc_A", read_dataA, 32'h12345678);
`else
        check("same_cyc_A", read_dataA, 32'h00000000);
`endif
        read_addrB = 32'h4;
        step();
        check("next_B", read_dataB, 32'h12345678);
        check("same_addr_AB", read_dataA, 32'h12345678);
        check("no_err_yet", addr_err, 0);
        read_addrB = '0;

        read_addrA = 32'h40;
        step();
        check("oor_rdA", read_dataA, 0);
        check("oor_err", addr_err, 1);
        read_addrA = '0;
        wr(32'h2, 32'hFFFFFFFF, 4'b1111);
        step();
        check("misalign_drop", read_dataA, 0);
        check("err_sticky", addr_err, 1);

        for (int i = 0; i < 16; i++) wr(4 * i, 32'h11111111 * (i + 1), 4'b1111);
        read_addrA = 32'h3C;
        step();
        check("fill_last", read_dataA, 32'h11111111 * 16);
        read_addrA = '0;

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("clr_busy", busy, 1);
        check("clr_err", addr_err, 0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            clear_req = (n == 5);
            step();
        end
        clear_req = 1'b0;
        check("restart_len", n, 21);
        read_all_zero("clr");
        check("clr_err_after", addr_err, 0);

        wr(32'hC, 32'hCAFE0001, 4'b1111);
        read_addrA = 32'hC;
        read_addrB = 32'h44;
        step();
        check("pre_rst_A", read_dataA, 32'hCAFE0001);
        check("pre_rst_err", addr_err, 1);
        #2 reset = 1'b0;
        #1;
        check("async_A", read_dataA, 0);
        check("async_err", addr_err, 0);
        check("async_busy", busy, 1);
        #1 reset = 1'b1;
        read_addrB = '0;
        count_busy("rst_access_sweep");

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check("mid_busy", busy, 1);
        check("mid_rdA", read_dataA, 0);
        #1 reset = 1'b1;
        count_busy("rst_sweep_len");
        read_addrA = 32'hC;
        step();
        check("word3_cleared", read_dataA, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
